// File: rtl/sudoku_pkg.sv
// Shared types and constants for the Sudoku player input controller.
// Board geometry, FSM state encoding, button indices and the action picker.
package sudoku_pkg;

  localparam int CELL_W      = 3;
  localparam int IDX_W       = 4;
  localparam int BOARD_CELLS = 16;
  localparam int NUM_BTN     = 5;

  localparam int BTN_RIGHT  = 0;
  localparam int BTN_DOWN   = 1;
  localparam int BTN_INC    = 2;
  localparam int BTN_COMMIT = 3;
  localparam int BTN_CHECK  = 4;

  typedef enum logic [2:0] {
    IDLE,
    EDIT,
    WRITE,
    CHECK,
    WAIT_RES,
    DONE
  } state_t;

  typedef enum logic [2:0] {
    ACT_NONE,
    ACT_RIGHT,
    ACT_DOWN,
    ACT_INC,
    ACT_COMMIT,
    ACT_CHECK
  } action_t;

  // Only the highest-priority edge survives; lower ones are dropped.
  function automatic action_t pick_action(input logic [NUM_BTN-1:0] e);
    if (e[BTN_CHECK])  return ACT_CHECK;
    if (e[BTN_COMMIT]) return ACT_COMMIT;
    if (e[BTN_RIGHT])  return ACT_RIGHT;
    if (e[BTN_DOWN])   return ACT_DOWN;
    if (e[BTN_INC])    return ACT_INC;
    return ACT_NONE;
  endfunction

endpackage

// File: rtl/sudoku_input_ctrl_btn_edge.sv
// Push-button conditioner: 2-flop synchronizer, optional debounce
// (SUDOKU_DEBOUNCE_EN) and registered rising-edge pulse.
module btn_edge #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clka,
  input  logic restart,
  input  logic lvl,
  output logic rise
);

  logic sync_p0;
  logic sync_p1;
  logic lvl_p2;
  logic rise_p3;
  logic stable;

`ifdef SUDOKU_DEBOUNCE_EN
  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

  logic [CNT_W-1:0] cnt;
  logic             deb;

  // Debounced level flips only after DEBOUNCE_CYCLES consecutive disagreeing samples.
  always_ff @(posedge clka) begin
    if (restart) begin
      cnt <= '0;
      deb <= 1'b0;
    end else if (sync_p1 != deb) begin
      if (cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
        deb <= sync_p1;
        cnt <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end else begin
      cnt <= '0;
    end
  end

  assign stable = deb;
`else
  assign stable = sync_p1;
`endif

  always_ff @(posedge clka) begin
    if (restart) begin
      sync_p0 <= 1'b0;
      sync_p1 <= 1'b0;
      lvl_p2  <= 1'b0;
      rise_p3 <= 1'b0;
    end else begin
      // p0/p1: metastability synchronizer
      sync_p0 <= lvl;
      sync_p1 <= sync_p0;
      // p2/p3: delayed level and registered rising edge
      lvl_p2  <= stable;
      rise_p3 <= stable & ~lvl_p2;
    end
  end

  assign rise = rise_p3;

endmodule

// File: rtl/sudoku_input_ctrl.sv
// Player-side initiator for the 4x4 Sudoku datapath: buttons -> cursor/value
// edits, write strobes and check requests. Optional debounce: SUDOKU_DEBOUNCE_EN.
module sudoku_input_ctrl
  import sudoku_pkg::*;
#(
  parameter int MAX_VAL         = 4,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic                   clka,
  input  logic                   restart,
  input  logic                   board_ready,
  input  logic                   btn_right,
  input  logic                   btn_down,
  input  logic                   btn_inc,
  input  logic                   btn_commit,
  input  logic                   btn_check,
  input  logic [BOARD_CELLS-1:0] fill_flag,
  input  logic                   result_valid,
  input  logic                   solved,
  output logic [IDX_W-1:0]       reg_choose,
  output logic [CELL_W-1:0]      value_inp,
  output logic                   register_inp_flag,
  output logic                   dp_check,
  output logic                   write_err,
  output logic                   try_again_flag,
  output logic                   won,
  output logic [IDX_W-1:0]       cursor,
  output logic [CELL_W-1:0]      pend_val
);

  localparam int HALF_W = IDX_W / 2;

  logic [NUM_BTN-1:0] btn_lvl;
  logic [NUM_BTN-1:0] btn_rise;
  action_t            act;

  assign btn_lvl[BTN_RIGHT]  = btn_right;
  assign btn_lvl[BTN_DOWN]   = btn_down;
  assign btn_lvl[BTN_INC]    = btn_inc;
  assign btn_lvl[BTN_COMMIT] = btn_commit;
  assign btn_lvl[BTN_CHECK]  = btn_check;

  for (genvar g = 0; g < NUM_BTN; g++) begin : g_btn
    btn_edge #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_btn_edge (
      .clka   (clka),
      .restart(restart),
      .lvl    (btn_lvl[g]),
      .rise   (btn_rise[g])
    );
  end

  assign act = pick_action(btn_rise);

  state_t              state_q, state_n;
  logic [IDX_W-1:0]    cursor_q, cursor_n;
  logic [CELL_W-1:0]   pend_q, pend_n;
  logic [IDX_W-1:0]    reg_choose_q, reg_choose_n;
  logic [CELL_W-1:0]   value_q, value_n;
  logic                write_err_q, write_err_n;
  logic                try_again_q, try_again_n;

  logic [HALF_W-1:0]   row, col;

  assign row = cursor_q[IDX_W-1:HALF_W];
  assign col = cursor_q[HALF_W-1:0];

  always_comb begin
    state_n      = state_q;
    cursor_n     = cursor_q;
    pend_n       = pend_q;
    reg_choose_n = reg_choose_q;
    value_n      = value_q;
    write_err_n  = 1'b0;
    try_again_n  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (board_ready) state_n = EDIT;
      end

      EDIT: begin
        unique case (act)
          ACT_CHECK: state_n = CHECK;
          ACT_COMMIT: begin
            if (fill_flag[cursor_q]) begin
              write_err_n = 1'b1;
            end else begin
              state_n      = WRITE;
              reg_choose_n = cursor_q;
              value_n      = pend_q;
            end
          end
          ACT_RIGHT: begin
            cursor_n = {row, col + HALF_W'(1)};
            pend_n   = '0;
          end
          ACT_DOWN: begin
            cursor_n = {row + HALF_W'(1), col};
            pend_n   = '0;
          end
          ACT_INC: begin
            pend_n = (pend_q == CELL_W'(MAX_VAL)) ? '0 : pend_q + CELL_W'(1);
          end
          default: ;
        endcase
      end

      WRITE: state_n = EDIT;

      CHECK: state_n = WAIT_RES;

      // Button edges arriving here are simply not looked at, so they are lost.
      WAIT_RES: begin
        if (result_valid) begin
          if (solved) begin
            state_n = DONE;
          end else begin
            try_again_n = 1'b1;
            state_n     = EDIT;
          end
        end
      end

      DONE: ;

      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clka) begin
    if (restart) begin
      state_q      <= IDLE;
      cursor_q     <= '0;
      pend_q       <= '0;
      reg_choose_q <= '0;
      value_q      <= '0;
      write_err_q  <= 1'b0;
      try_again_q  <= 1'b0;
    end else begin
      state_q      <= state_n;
      cursor_q     <= cursor_n;
      pend_q       <= pend_n;
      reg_choose_q <= reg_choose_n;
      value_q      <= value_n;
      write_err_q  <= write_err_n;
      try_again_q  <= try_again_n;
    end
  end

  assign reg_choose        = reg_choose_q;
  assign value_inp         = value_q;
  assign register_inp_flag = (state_q == WRITE);
  assign dp_check          = (state_q == CHECK);
  assign won               = (state_q == DONE);
  assign write_err         = write_err_q;
  assign try_again_flag    = try_again_q;
  assign cursor            = cursor_q;
  assign pend_val          = pend_q;

endmodule
